// File: rtl/ppu_pkg.sv
// ppu_pkg: shared register indices, VRAM port FSM states and palette helpers for the PPU register block.
package ppu_pkg;
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;
  localparam logic [13:0] PAL_BASE = 14'h3F00;
  typedef enum logic [2:0] {IDLE, WR_WAIT, RD_WAIT, RD_LATCH, FINISH} vram_state_e;
  // Sprite backdrop entries $10/$14/$18/$1C alias the background ones.
  function automatic logic [4:0] pal_index(input logic [13:0] a);
    return (a[4] && a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a[4:0];
  endfunction
endpackage

// File: rtl/ppu_vram_port.sv
// ppu_vram_port: PPUDATA transfer FSM, VRAM address v and read buffer.
module ppu_vram_port
  import ppu_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_wr,
  input  logic        start_rd,
  input  logic [7:0]  wdata,
  input  logic        v_load,
  input  logic [13:0] v_load_val,
  input  logic        v_step,
  input  logic [13:0] step,
  input  logic        vram_ack,
  input  logic [7:0]  ppu_in,
  output logic        vram_req,
  output logic [13:0] ppu_addr,
  output logic [7:0]  ppu_out,
  output logic        ppu_we,
  output logic        lock_cpu,
  output logic [13:0] v,
  output logic [7:0]  buffer
);
  vram_state_e state, state_nx;
  logic [13:0] addr_q;
  logic slot;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = start_wr ? WR_WAIT : start_rd ? RD_WAIT : IDLE;
      WR_WAIT:  state_nx = vram_ack ? FINISH : WR_WAIT;
      RD_WAIT:  state_nx = vram_ack ? RD_LATCH : RD_WAIT;
      RD_LATCH: state_nx = FINISH;
      default:  state_nx = IDLE;
    endcase
  end
  // Palette-range reads still refill the buffer from the nametable underneath.
  always_comb begin
    vram_req = state == WR_WAIT || state == RD_WAIT;
    slot = vram_req & vram_ack;
    ppu_we = slot & (state == WR_WAIT);
    lock_cpu = state != IDLE;
    ppu_addr = slot ? ((v[13:8] == PAL_BASE[13:8]) ? v & 14'h2FFF : v) : addr_q;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      addr_q <= '0;
      ppu_out <= '0;
      buffer <= '0;
      v <= '0;
    end else begin
      addr_q <= ppu_addr;
      if (start_wr) ppu_out <= wdata;
      if (state == RD_LATCH) buffer <= ppu_in;
      v <= v_load ? v_load_val : (v_step || state == FINISH) ? v + step : v;
    end
endmodule

// File: rtl/ppu_regs.sv
// ppu_regs: CPU-facing PPU register file at $2000-$3FFF with write toggle, vblank/NMI and PPUDATA transfers.
module ppu_regs
  import ppu_pkg::*;
#(
  parameter logic [2:0] CS_HI = 3'b001,
  parameter int INC_SMALL = 1,
  parameter int INC_LARGE = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  in,
  input  logic        rd,
  input  logic        we,
  output logic [7:0]  out,
  output logic        lock_cpu,
  input  logic        vblank_start,
  input  logic        vblank_end,
  input  logic        spr0_hit,
  input  logic        spr_ovf,
  output logic        vram_req,
  input  logic        vram_ack,
  output logic [13:0] ppu_addr,
  input  logic [7:0]  ppu_in,
  output logic [7:0]  ppu_out,
  output logic        ppu_we,
  output logic [4:0]  pal_addr,
  input  logic [5:0]  pal_in,
  output logic [5:0]  pal_out,
  output logic        pal_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_out,
  output logic        oam_we,
  output logic [7:0]  ctrl,
  output logic [7:0]  mask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic        nmi_n
);
  logic [2:0] ra;
  logic acc, wr, rd_acc, pal_hit, status_rd, w, vblank, vblank_nx;
  logic [7:0] ctrl_nx, buffer;
  logic [13:0] t, v;
  assign ra = address[2:0];
  assign acc = (address[15:13] == CS_HI) & (rd | we) & ~lock_cpu;
  assign wr = acc & we;
  assign rd_acc = acc & rd & ~we;
  assign pal_hit = v[13:8] == PAL_BASE[13:8];
  assign status_rd = rd_acc & (ra == REG_STATUS);
  assign pal_we = wr & (ra == REG_DATA) & pal_hit;
  assign pal_out = in[5:0];
  assign pal_addr = pal_index(v);
  // A status read racing vblank_start wins, so the flag is never seen set.
  assign vblank_nx = status_rd ? 1'b0 : vblank_start ? 1'b1 : vblank_end ? 1'b0 : vblank;
  assign ctrl_nx = (wr && ra == REG_CTRL) ? in : ctrl;
  ppu_vram_port u_port (
    .clock(clock), .reset_n(reset_n),
    .start_wr(wr & (ra == REG_DATA) & ~pal_hit), .start_rd(rd_acc & (ra == REG_DATA)),
    .wdata(in), .v_load(wr & (ra == REG_ADDR) & w), .v_load_val({t[13:8], in}),
    .v_step(pal_we), .step(ctrl[2] ? 14'(INC_LARGE) : 14'(INC_SMALL)),
    .vram_ack(vram_ack), .ppu_in(ppu_in), .vram_req(vram_req), .ppu_addr(ppu_addr),
    .ppu_out(ppu_out), .ppu_we(ppu_we), .lock_cpu(lock_cpu), .v(v), .buffer(buffer)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ctrl <= '0;
      mask <= '0;
      scroll_x <= '0;
      scroll_y <= '0;
      oam_addr <= '0;
      oam_out <= '0;
      oam_we <= 1'b0;
      t <= '0;
      w <= 1'b0;
      vblank <= 1'b0;
      nmi_n <= 1'b1;
      out <= '0;
    end else begin
      ctrl <= ctrl_nx;
      vblank <= vblank_nx;
      nmi_n <= ~(vblank_nx & ctrl_nx[7]);
      oam_we <= wr & (ra == REG_OAMDATA);
      if (wr && ra == REG_MASK) mask <= in;
      if (wr && ra == REG_OAMADDR) oam_addr <= in;
      else if (oam_we) oam_addr <= oam_addr + 8'd1;
      if (wr && ra == REG_OAMDATA) oam_out <= in;
      if (wr && ra == REG_SCROLL && !w) scroll_x <= in;
      if (wr && ra == REG_SCROLL && w) scroll_y <= in;
      if (wr && ra == REG_ADDR && !w) t[13:8] <= in[5:0];
      if (wr && ra == REG_ADDR && w) t[7:0] <= in;
      if (status_rd) w <= 1'b0;
      else if (wr && (ra == REG_SCROLL || ra == REG_ADDR)) w <= ~w;
      if (rd_acc)
        out <= (ra == REG_STATUS) ? {vblank & ~vblank_start, spr0_hit, spr_ovf, 5'b0} :
               (ra == REG_DATA) ? (pal_hit ? {2'b00, pal_in} : buffer) : 8'h00;
    end
endmodule

// File: tb/tb_ppu_regs.sv
// tb_ppu_regs: directed self-checking bench for the PPU register block.
module tb_ppu_regs;
  logic clock = 0, reset_n = 0;
  logic [15:0] address = '0;
  logic [7:0] in = '0;
  logic rd = 0, we = 0, vblank_start = 0, vblank_end = 0, spr0_hit = 0, spr_ovf = 0, vram_ack = 0;
  logic [7:0] out, ppu_in, ppu_out, oam_addr, oam_out, ctrl, mask, scroll_x, scroll_y;
  logic lock_cpu, vram_req, ppu_we, pal_we, oam_we, nmi_n;
  logic [13:0] ppu_addr;
  logic [4:0] pal_addr;
  logic [5:0] pal_in, pal_out;
  logic [7:0] vram [0:16383];
  int checks = 0, errors = 0;
  int x_lock, x_req, x_we;
  logic [13:0] x_addr;
  logic [7:0] x_data;

  ppu_regs dut (
    .clock(clock), .reset_n(reset_n), .address(address), .in(in), .rd(rd), .we(we),
    .out(out), .lock_cpu(lock_cpu), .vblank_start(vblank_start), .vblank_end(vblank_end),
    .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .vram_req(vram_req), .vram_ack(vram_ack),
    .ppu_addr(ppu_addr), .ppu_in(ppu_in), .ppu_out(ppu_out), .ppu_we(ppu_we),
    .pal_addr(pal_addr), .pal_in(pal_in), .pal_out(pal_out), .pal_we(pal_we),
    .oam_addr(oam_addr), .oam_out(oam_out), .oam_we(oam_we), .ctrl(ctrl), .mask(mask),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .nmi_n(nmi_n)
  );

  always #5 clock = ~clock;
  assign ppu_in = vram[ppu_addr];
  assign pal_in = {1'b1, pal_addr};

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock); address = a; in = d; we = 1;
    @(negedge clock); we = 0; #1;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    @(negedge clock); address = a; rd = 1;
    @(negedge clock); rd = 0; #1;
  endtask

  task automatic xfer(input logic is_wr, input logic [7:0] d, input int dly);
    @(negedge clock); address = 16'h2007; in = d; we = is_wr; rd = ~is_wr;
    @(negedge clock); we = 0; rd = 0;
    x_lock = 0; x_req = 0; x_we = 0; x_addr = 'x; x_data = 'x;
    for (int i = 0; i < 20; i++) begin
      vram_ack = (i == dly);
      #1;
      if (lock_cpu) x_lock++;
      if (vram_req) x_req++;
      if (vram_ack && vram_req) x_addr = ppu_addr;
      if (ppu_we) begin x_we++; x_data = ppu_out; vram[ppu_addr] = ppu_out; end
      @(negedge clock);
    end
    vram_ack = 0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({nmi_n, lock_cpu, vram_req, ppu_we, pal_we, oam_we} !== 6'b100000) begin errors++; $display("FAIL reset_strobes got %b exp 100000", {nmi_n, lock_cpu, vram_req, ppu_we, pal_we, oam_we}); end
    checks++; if ({ctrl, mask, scroll_x, scroll_y, out, oam_addr} !== 48'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {ctrl, mask, scroll_x, scroll_y, out, oam_addr}); end
    @(negedge clock); reset_n = 1;
    @(negedge clock); #1;
    checks++; if ({nmi_n, lock_cpu, out} !== 10'b10_0000_0000) begin errors++; $display("FAIL post_reset got %b exp 1000000000", {nmi_n, lock_cpu, out}); end
  endtask

  task automatic test_addr_write;
    cpu_wr(16'h2006, 8'h21);
    cpu_wr(16'h2006, 8'h08);
    xfer(1, 8'h55, 3);
    checks++; if (x_lock !== 5) begin errors++; $display("FAIL wr_lock_cycles got %0d exp 5", x_lock); end
    checks++; if (x_we !== 1) begin errors++; $display("FAIL wr_we_count got %0d exp 1", x_we); end
    checks++; if (x_addr !== 14'h2108) begin errors++; $display("FAIL wr_addr got %h exp 2108", x_addr); end
    checks++; if (x_data !== 8'h55) begin errors++; $display("FAIL wr_data got %h exp 55", x_data); end
    checks++; if (x_req !== 4) begin errors++; $display("FAIL wr_req_cycles got %0d exp 4", x_req); end
    xfer(1, 8'h66, 0);
    checks++; if (x_addr !== 14'h2109) begin errors++; $display("FAIL wr_v_inc got %h exp 2109", x_addr); end
    checks++; if (x_lock !== 2) begin errors++; $display("FAIL wr_lock_fast got %0d exp 2", x_lock); end
  endtask

  task automatic test_buffered_read;
    vram[14'h2000] = 8'hAA; vram[14'h2020] = 8'hBB; vram[14'h2040] = 8'hCC;
    cpu_wr(16'h2000, 8'h04);
    cpu_wr(16'h2006, 8'h20);
    cpu_wr(16'h2006, 8'h00);
    xfer(0, 8'h00, 2);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL rd_stale got %h exp 00", out); end
    checks++; if (x_addr !== 14'h2000) begin errors++; $display("FAIL rd_addr0 got %h exp 2000", x_addr); end
    checks++; if (x_lock !== 5) begin errors++; $display("FAIL rd_lock_cycles got %0d exp 5", x_lock); end
    xfer(0, 8'h00, 0);
    checks++; if (out !== 8'hAA) begin errors++; $display("FAIL rd_first got %h exp AA", out); end
    checks++; if (x_addr !== 14'h2020) begin errors++; $display("FAIL rd_addr1 got %h exp 2020", x_addr); end
    xfer(0, 8'h00, 0);
    checks++; if (out !== 8'hBB) begin errors++; $display("FAIL rd_second got %h exp BB", out); end
    checks++; if (x_addr !== 14'h2040) begin errors++; $display("FAIL rd_v_inc32 got %h exp 2040", x_addr); end
  endtask

  task automatic test_palette;
    vram[14'h2F14] = 8'h00;
    cpu_wr(16'h2000, 8'h00);
    cpu_wr(16'h2006, 8'h3F);
    cpu_wr(16'h2006, 8'h10);
    @(negedge clock); address = 16'h2007; in = 8'h2C; we = 1; #1;
    checks++; if ({pal_we, pal_addr, pal_out} !== {1'b1, 5'h00, 6'h2C}) begin errors++; $display("FAIL pal_write got %b/%h/%h exp 1/00/2C", pal_we, pal_addr, pal_out); end
    @(negedge clock); we = 0; #1;
    checks++; if ({pal_we, vram_req, lock_cpu} !== 3'b000) begin errors++; $display("FAIL pal_no_fsm got %b exp 000", {pal_we, vram_req, lock_cpu}); end
    checks++; if (pal_addr !== 5'h11) begin errors++; $display("FAIL pal_v_inc got %h exp 11", pal_addr); end
    cpu_wr(16'h2006, 8'h3F);
    cpu_wr(16'h2006, 8'h14);
    xfer(0, 8'h00, 1);
    checks++; if (out !== 8'h24) begin errors++; $display("FAIL pal_read got %h exp 24", out); end
    checks++; if (x_addr !== 14'h2F14) begin errors++; $display("FAIL pal_refill_addr got %h exp 2F14", x_addr); end
  endtask

  task automatic test_vblank_nmi;
    cpu_wr(16'h2000, 8'h80);
    @(negedge clock); vblank_start = 1;
    @(negedge clock); vblank_start = 0; #1;
    checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL nmi_assert got %b exp 0", nmi_n); end
    cpu_rd(16'h2002);
    checks++; if (out !== 8'h80) begin errors++; $display("FAIL status_vblank got %h exp 80", out); end
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL nmi_release got %b exp 1", nmi_n); end
    @(negedge clock); address = 16'h2002; rd = 1; vblank_start = 1;
    @(negedge clock); rd = 0; vblank_start = 0; #1;
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL suppress_read got %h exp 00", out); end
    @(negedge clock); #1;
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL suppress_nmi got %b exp 1", nmi_n); end
    cpu_wr(16'h2000, 8'h00);
    @(negedge clock); vblank_start = 1;
    @(negedge clock); vblank_start = 0; #1;
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL nmi_masked got %b exp 1", nmi_n); end
    cpu_wr(16'h2000, 8'h80);
    checks++; if (nmi_n !== 1'b0) begin errors++; $display("FAIL nmi_late_enable got %b exp 0", nmi_n); end
    @(negedge clock); vblank_end = 1;
    @(negedge clock); vblank_end = 0; #1;
    checks++; if (nmi_n !== 1'b1) begin errors++; $display("FAIL vblank_end_nmi got %b exp 1", nmi_n); end
    cpu_wr(16'h2000, 8'h00);
  endtask

  task automatic test_toggle;
    cpu_wr(16'h2005, 8'h12);
    cpu_rd(16'h2002);
    cpu_wr(16'h2005, 8'h34);
    checks++; if ({scroll_x, scroll_y} !== 16'h3400) begin errors++; $display("FAIL toggle_reset got %h exp 3400", {scroll_x, scroll_y}); end
    cpu_wr(16'h2005, 8'h56);
    checks++; if ({scroll_x, scroll_y} !== 16'h3456) begin errors++; $display("FAIL scroll_y got %h exp 3456", {scroll_x, scroll_y}); end
  endtask

  task automatic test_oam_mirror;
    cpu_wr(16'h2003, 8'h10);
    cpu_wr(16'h4003, 8'h77);
    checks++; if (oam_addr !== 8'h10) begin errors++; $display("FAIL unselected_write got %h exp 10", oam_addr); end
    cpu_wr(16'h3FFC, 8'hAB);
    checks++; if ({oam_we, oam_out, oam_addr} !== {1'b1, 8'hAB, 8'h10}) begin errors++; $display("FAIL oam_write got %b/%h/%h exp 1/AB/10", oam_we, oam_out, oam_addr); end
    @(negedge clock); #1;
    checks++; if ({oam_we, oam_addr} !== {1'b0, 8'h11}) begin errors++; $display("FAIL oam_inc got %b/%h exp 0/11", oam_we, oam_addr); end
    spr0_hit = 1;
    cpu_rd(16'h2002);
    spr0_hit = 0;
    checks++; if (out !== 8'h40) begin errors++; $display("FAIL status_spr0 got %h exp 40", out); end
    cpu_rd(16'h2004);
    checks++; if (out !== 8'h00) begin errors++; $display("FAIL oam_read got %h exp 00", out); end
    cpu_wr(16'h2001, 8'h1E);
    checks++; if (mask !== 8'h1E) begin errors++; $display("FAIL mask_write got %h exp 1E", mask); end
  endtask

  task automatic test_mid_reset;
    int we_seen;
    we_seen = 0;
    cpu_wr(16'h2006, 8'h24);
    cpu_wr(16'h2006, 8'h00);
    @(negedge clock); address = 16'h2007; in = 8'h99; we = 1;
    @(negedge clock); we = 0; #1;
    checks++; if (lock_cpu !== 1'b1) begin errors++; $display("FAIL midrst_locked got %b exp 1", lock_cpu); end
    #1 reset_n = 0; #1;
    checks++; if ({lock_cpu, vram_req} !== 2'b00) begin errors++; $display("FAIL midrst_release got %b exp 00", {lock_cpu, vram_req}); end
    vram_ack = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      if (i == 2) reset_n = 1;
      if (ppu_we) we_seen++;
    end
    vram_ack = 0;
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL midrst_no_we got %0d exp 0", we_seen); end
    checks++; if ({lock_cpu, ctrl, mask} !== 17'h0) begin errors++; $display("FAIL midrst_state got %h exp 0", {lock_cpu, ctrl, mask}); end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_buffered_read();
    test_palette();
    test_vblank_nmi();
    test_toggle();
    test_oam_mirror();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
